// File: rtl/ranger_pkg.sv
// Shared types and default timing constants for the echo ranger.
package ranger_pkg;

  localparam int DIST_W = 21;

  // Defaults assume a 50 MHz clk: 10 us trigger, 60 ms period, 30 ms timeout.
  localparam int DEF_TRIG_CYCLES    = 500;
  localparam int DEF_PERIOD_CYCLES  = 3_000_000;
  localparam int DEF_TIMEOUT_CYCLES = 1_500_000;

  typedef logic [DIST_W-1:0] dist_t;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    DONE
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Double register the raw input to settle metastability before use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/echo_ranger.sv
// Ultrasonic echo ranger: periodic trigger pulse, echo high-time measurement
// with timeout. Optional feature macro AVG4_EN: report the mean of the last
// four results (one extra cycle of latency on dist_valid).
module echo_ranger
  import ranger_pkg::*;
#(
  parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        echo,
  output logic        trig,
  output logic [20:0] distance_raw,
  output logic        dist_valid,
  output logic        timeout
);

  localparam int TCW = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;
  localparam int PCW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int OCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [TCW-1:0] T_LAST    = TCW'(TRIG_CYCLES - 1);
  localparam logic [PCW-1:0] P_LAST    = PCW'(PERIOD_CYCLES - 1);
  localparam logic [OCW-1:0] TO_LAST   = OCW'(TIMEOUT_CYCLES - 1);
  localparam dist_t          TO_RESULT = dist_t'(TIMEOUT_CYCLES);
  localparam dist_t          DIST_MAX  = '1;

  // Saturating increment for the echo counter; holds at all-ones.
  function automatic dist_t sat_inc(input dist_t v);
    return (v == DIST_MAX) ? v : v + dist_t'(1);
  endfunction

  logic echo_s;
  logic echo_rise;

  state_e         state_q,      state_d;
  logic [TCW-1:0] trig_cnt_q,   trig_cnt_d;
  logic [PCW-1:0] period_cnt_q, period_cnt_d;
  logic [OCW-1:0] to_cnt_q,     to_cnt_d;
  dist_t          echo_cnt_q,   echo_cnt_d;
  logic           echo_prev_q,  echo_prev_d;
  logic           start_pend_q, start_pend_d;
  logic           trig_q,       trig_d;
  dist_t          res_q,        res_d;
  logic           res_to_q,     res_to_d;
  logic           res_vld_q,    res_vld_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (echo),
    .q   (echo_s)
  );

  // A start needs a fresh 0->1 on echo_s, so a line stuck high never qualifies.
  assign echo_rise = echo_s & ~echo_prev_q;

  // Next-state, counters and result capture for the measurement FSM.
  always_comb begin
    state_d      = state_q;
    trig_cnt_d   = trig_cnt_q;
    period_cnt_d = (period_cnt_q == P_LAST) ? period_cnt_q : period_cnt_q + PCW'(1);
    to_cnt_d     = to_cnt_q;
    echo_cnt_d   = echo_cnt_q;
    echo_prev_d  = echo_s;
    start_pend_d = start_pend_q;
    res_d        = res_q;
    res_to_d     = res_to_q;
    res_vld_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_pend_q || (period_cnt_q == P_LAST)) begin
          state_d      = TRIG;
          trig_cnt_d   = '0;
          period_cnt_d = '0;
          start_pend_d = 1'b0;
        end
      end
      TRIG: begin
        if (trig_cnt_q == T_LAST) begin
          state_d  = WAIT_RISE;
          to_cnt_d = '0;
        end else begin
          trig_cnt_d = trig_cnt_q + TCW'(1);
        end
      end
      WAIT_RISE: begin
        if (to_cnt_q == TO_LAST) begin
          state_d   = DONE;
          res_d     = TO_RESULT;
          res_to_d  = 1'b1;
          res_vld_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + OCW'(1);
          if (echo_rise) begin
            state_d    = MEASURE;
            echo_cnt_d = dist_t'(1);
          end
        end
      end
      MEASURE: begin
        // Timeout takes priority over a falling edge in the same cycle.
        if (to_cnt_q == TO_LAST) begin
          state_d   = DONE;
          res_d     = TO_RESULT;
          res_to_d  = 1'b1;
          res_vld_d = 1'b1;
        end else if (!echo_s) begin
          state_d   = DONE;
          res_d     = echo_cnt_q;
          res_to_d  = 1'b0;
          res_vld_d = 1'b1;
        end else begin
          to_cnt_d   = to_cnt_q + OCW'(1);
          echo_cnt_d = sat_inc(echo_cnt_q);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    trig_d = (state_d == TRIG);
  end

  // State and counter registers; reset aborts any measurement and drops trig at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      trig_cnt_q   <= '0;
      period_cnt_q <= '0;
      to_cnt_q     <= '0;
      echo_cnt_q   <= '0;
      echo_prev_q  <= 1'b0;
      start_pend_q <= 1'b1;
      trig_q       <= 1'b0;
      res_q        <= '0;
      res_to_q     <= 1'b0;
      res_vld_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      trig_cnt_q   <= trig_cnt_d;
      period_cnt_q <= period_cnt_d;
      to_cnt_q     <= to_cnt_d;
      echo_cnt_q   <= echo_cnt_d;
      echo_prev_q  <= echo_prev_d;
      start_pend_q <= start_pend_d;
      trig_q       <= trig_d;
      res_q        <= res_d;
      res_to_q     <= res_to_d;
      res_vld_q    <= res_vld_d;
    end
  end

  assign trig = trig_q;

`ifdef AVG4_EN
  dist_t              hist0_q, hist0_d;
  dist_t              hist1_q, hist1_d;
  dist_t              hist2_q, hist2_d;
  dist_t              avg_q,   avg_d;
  logic               avg_to_q,  avg_to_d;
  logic               avg_vld_q, avg_vld_d;
  logic [DIST_W+1:0]  sum_c;

  // Fold each new result into a four-deep history and average it.
  always_comb begin
    sum_c     = (DIST_W+2)'(res_q) + (DIST_W+2)'(hist0_q)
              + (DIST_W+2)'(hist1_q) + (DIST_W+2)'(hist2_q);
    hist0_d   = hist0_q;
    hist1_d   = hist1_q;
    hist2_d   = hist2_q;
    avg_d     = avg_q;
    avg_to_d  = avg_to_q;
    avg_vld_d = res_vld_q;
    if (res_vld_q) begin
      hist2_d  = hist1_q;
      hist1_d  = hist0_q;
      hist0_d  = res_q;
      avg_d    = sum_c[DIST_W+1:2];
      avg_to_d = res_to_q;
    end
  end

  // History and averaged output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist0_q   <= '0;
      hist1_q   <= '0;
      hist2_q   <= '0;
      avg_q     <= '0;
      avg_to_q  <= 1'b0;
      avg_vld_q <= 1'b0;
    end else begin
      hist0_q   <= hist0_d;
      hist1_q   <= hist1_d;
      hist2_q   <= hist2_d;
      avg_q     <= avg_d;
      avg_to_q  <= avg_to_d;
      avg_vld_q <= avg_vld_d;
    end
  end

  assign distance_raw = avg_q;
  assign dist_valid   = avg_vld_q;
  assign timeout      = avg_to_q;
`else
  assign distance_raw = res_q;
  assign dist_valid   = res_vld_q;
  assign timeout      = res_to_q;
`endif

endmodule
